fetch_redirect: RTL and testbench

- Fetch stage of the 5-stage pipeline. Owns the PC register and the IF/ID pipeline register.
- Issues requests to a variable-latency instruction memory using a Rd/Done handshake.
- Consumes the PC redirect that execute produces (branch taken or ALU jump) and squashes wrong-path fetches.
- Honours the hazard-unit stall and the decode-stage HALT.

---
 rtl/fetch_redirect_pkg.sv | 22 ++
 rtl/ifid_reg.sv | 56 +++++
 rtl/fetch_redirect.sv | 144 ++++++++++++++
 tb/tb_fetch_redirect.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_pkg.sv
// Shared definitions for the fetch stage: FSM encoding, pipeline constants
// and the IF/ID bundle layout.
package fetch_redirect_pkg;

   localparam logic [15:0] IFID_NOP_INSTR = 16'h0800;
   localparam logic [15:0] FETCH_PC_INC   = 16'h0002;

   typedef enum logic [2:0] {
      FETCH_REQ    = 3'd0,
      FETCH_WAIT   = 3'd1,
      FETCH_DRAIN  = 3'd2,
      FETCH_HOLD   = 3'd3,
      FETCH_HALTED = 3'd4
   } fetch_state_e;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] pc;
      logic        valid;
   } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats load, load beats hold, otherwise a
// bubble is inserted. Asynchronous clear on rst.
module ifid_reg
   import fetch_redirect_pkg::*;
#(
   parameter logic [15:0] NOP_INSTR = IFID_NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        load,
   input  logic        hold,
   input  logic [15:0] load_instr,
   input  logic [15:0] load_pc,
   output logic [15:0] instr,
   output logic [15:0] pc,
   output logic        valid
);

   ifid_t ifid_r;
   ifid_t ifid_nxt_s;

   // next IF/ID contents
   always_comb begin
      ifid_nxt_s = ifid_r;
      if (flush) begin
         ifid_nxt_s.instr = NOP_INSTR;
         ifid_nxt_s.valid = 1'b0;
      end else if (load) begin
         ifid_nxt_s.instr = load_instr;
         ifid_nxt_s.pc    = load_pc;
         ifid_nxt_s.valid = 1'b1;
      end else if (hold) begin
         ifid_nxt_s = ifid_r;
      end else begin
         ifid_nxt_s.instr = NOP_INSTR;
         ifid_nxt_s.valid = 1'b0;
      end
   end

   // IF/ID state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_r.instr <= NOP_INSTR;
         ifid_r.pc    <= 16'h0000;
         ifid_r.valid <= 1'b0;
      end else begin
         ifid_r <= ifid_nxt_s;
      end
   end

   assign instr = ifid_r.instr;
   assign pc    = ifid_r.pc;
   assign valid = ifid_r.valid;

endmodule

// File: rtl/fetch_redirect.sv
// Fetch stage: PC register, Rd/Done instruction-memory handshake, redirect
// squashing, stall holding and HALT shutdown.
module fetch_redirect
   import fetch_redirect_pkg::*;
#(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = IFID_NOP_INSTR,
   parameter logic [15:0] PC_INC    = FETCH_PC_INC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        Redirect,
   input  logic [15:0] PC_Redirect,
   input  logic        Stall,
   input  logic        Halt_D,
   output logic        IMem_Rd,
   output logic [15:0] IMem_Addr,
   input  logic        IMem_Done,
   input  logic [15:0] IMem_Data,
   output logic [15:0] Instr_ff,
   output logic [15:0] PC_ff,
   output logic        Valid_ff,
   output logic        Halted
);

   fetch_state_e state_r, state_nxt_s;
   logic [15:0]  pc_r, pc_nxt_s, pc_inc_s;
   logic [15:0]  hold_instr_r, hold_pc_r;
   logic         hold_load_s, ifid_load_s;
   logic         halt_pend_r, halt_pend_nxt_s, halt_s;
   logic         halted_r;
   logic [15:0]  load_instr_s, load_pc_s;

   assign pc_inc_s  = pc_r + PC_INC;
   assign halt_s    = halt_pend_r | Halt_D;
   assign IMem_Rd   = (state_r == FETCH_REQ) & ~Redirect & ~halt_pend_r & ~rst;
   assign IMem_Addr = pc_r;
   assign Halted    = halted_r;

   // delivery comes straight from memory in WAIT, from the hold buffer in HOLD
   assign load_instr_s = (state_r == FETCH_HOLD) ? hold_instr_r : IMem_Data;
   assign load_pc_s    = (state_r == FETCH_HOLD) ? hold_pc_r    : pc_inc_s;

   // next-state, PC and IF/ID control
   always_comb begin
      state_nxt_s = state_r;
      ifid_load_s = 1'b0;
      hold_load_s = 1'b0;
      if (Redirect) begin
         pc_nxt_s        = PC_Redirect;
         halt_pend_nxt_s = 1'b0;
      end else begin
         pc_nxt_s        = pc_r;
         halt_pend_nxt_s = halt_s;
      end
      case (state_r)
         FETCH_REQ: begin
            if (Redirect)         state_nxt_s = FETCH_REQ;
            else if (halt_pend_r) state_nxt_s = FETCH_HALTED;
            else                  state_nxt_s = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (Redirect) begin
               state_nxt_s = IMem_Done ? FETCH_REQ : FETCH_DRAIN;
            end else if (IMem_Done) begin
               if (Stall) begin
                  hold_load_s = 1'b1;
                  pc_nxt_s    = pc_inc_s;
                  state_nxt_s = FETCH_HOLD;
               end else if (halt_s) begin
                  state_nxt_s = FETCH_HALTED;
               end else begin
                  ifid_load_s = 1'b1;
                  pc_nxt_s    = pc_inc_s;
                  state_nxt_s = FETCH_REQ;
               end
            end else begin
               state_nxt_s = FETCH_WAIT;
            end
         end
         FETCH_DRAIN: begin
            if (IMem_Done) state_nxt_s = (halt_s & ~Redirect) ? FETCH_HALTED : FETCH_REQ;
            else           state_nxt_s = FETCH_DRAIN;
         end
         FETCH_HOLD: begin
            if (Redirect) begin
               state_nxt_s = FETCH_REQ;
            end else if (Stall) begin
               state_nxt_s = FETCH_HOLD;
            end else if (halt_s) begin
               state_nxt_s = FETCH_HALTED;
            end else begin
               ifid_load_s = 1'b1;
               state_nxt_s = FETCH_REQ;
            end
         end
         FETCH_HALTED: begin
            if (Redirect) state_nxt_s = FETCH_REQ;
            else          state_nxt_s = FETCH_HALTED;
         end
         default: state_nxt_s = FETCH_REQ;
      endcase
   end

   // FSM, PC, halt and hold-buffer registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= FETCH_REQ;
         pc_r         <= RESET_PC;
         halt_pend_r  <= 1'b0;
         halted_r     <= 1'b0;
         hold_instr_r <= 16'h0000;
         hold_pc_r    <= 16'h0000;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         halt_pend_r <= halt_pend_nxt_s;
         halted_r    <= (state_nxt_s == FETCH_HALTED);
         if (hold_load_s) begin
            hold_instr_r <= IMem_Data;
            hold_pc_r    <= pc_inc_s;
         end else begin
            hold_instr_r <= hold_instr_r;
            hold_pc_r    <= hold_pc_r;
         end
      end
   end

   ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk        (clk),
      .rst        (rst),
      .flush      (Redirect),
      .load       (ifid_load_s),
      .hold       (Stall),
      .load_instr (load_instr_s),
      .load_pc    (load_pc_s),
      .instr      (Instr_ff),
      .pc         (PC_ff),
      .valid      (Valid_ff)
   );

endmodule

// File: tb/tb_fetch_redirect.sv
// Directed-vector bench for fetch_redirect with hand-computed expectations.
module tb_fetch_redirect;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Redirect = 1'b0;
   logic [15:0] PC_Redirect = 16'h0000;
   logic        Stall = 1'b0;
   logic        Halt_D = 1'b0;
   logic        IMem_Rd;
   logic [15:0] IMem_Addr;
   logic        IMem_Done = 1'b0;
   logic [15:0] IMem_Data = 16'h0000;
   logic [15:0] Instr_ff;
   logic [15:0] PC_ff;
   logic        Valid_ff;
   logic        Halted;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_redirect dut (
      .clk         (clk),
      .rst         (rst),
      .Redirect    (Redirect),
      .PC_Redirect (PC_Redirect),
      .Stall       (Stall),
      .Halt_D      (Halt_D),
      .IMem_Rd     (IMem_Rd),
      .IMem_Addr   (IMem_Addr),
      .IMem_Done   (IMem_Done),
      .IMem_Data   (IMem_Data),
      .Instr_ff    (Instr_ff),
      .PC_ff       (PC_ff),
      .Valid_ff    (Valid_ff),
      .Halted      (Halted)
   );

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // advance to just after the next rising edge, then let inputs settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [15:0] instr,
                           input logic [15:0] pc, input logic valid);
      check({tag, ".instr"}, Instr_ff, instr);
      check({tag, ".pc"},    PC_ff,    pc);
      check({tag, ".valid"}, {15'd0, Valid_ff}, {15'd0, valid});
   endtask

   initial begin
      // reset state
      step(); step();
      check("rst.rd",     {15'd0, IMem_Rd}, 16'h0000);
      check("rst.addr",   IMem_Addr, 16'h0000);
      check("rst.halted", {15'd0, Halted}, 16'h0000);
      chk_ifid("rst", 16'h0800, 16'h0000, 1'b0);

      // basic fetch: Done one cycle after Rd
      rst = 1'b0; #1;
      check("f1.rd",   {15'd0, IMem_Rd}, 16'h0001);
      check("f1.addr", IMem_Addr, 16'h0000);
      step();
      IMem_Done = 1'b1; IMem_Data = 16'h4001; #1;
      check("f1.wait_rd", {15'd0, IMem_Rd}, 16'h0000);
      step();
      IMem_Done = 1'b0; #1;
      chk_ifid("f1", 16'h4001, 16'h0002, 1'b1);
      check("f1.next_rd",   {15'd0, IMem_Rd}, 16'h0001);
      check("f1.next_addr", IMem_Addr, 16'h0002);

      // redirect coincident with Done
      step();
      IMem_Done = 1'b1; IMem_Data = 16'h1234; Redirect = 1'b1; PC_Redirect = 16'h0040; #1;
      step();
      IMem_Done = 1'b0; Redirect = 1'b0; #1;
      check("r1.valid", {15'd0, Valid_ff}, 16'h0000);
      check("r1.instr", Instr_ff, 16'h0800);
      check("r1.rd",    {15'd0, IMem_Rd}, 16'h0001);
      check("r1.addr",  IMem_Addr, 16'h0040);
      step();
      check("r1.stale_valid", {15'd0, Valid_ff}, 16'h0000);
      check("r1.stale_instr", Instr_ff, 16'h0800);

      // redirect during WAIT, Done three cycles later
      Redirect = 1'b1; PC_Redirect = 16'h0080; #1;
      step();
      Redirect = 1'b0; #1;
      check("d1.rd0", {15'd0, IMem_Rd}, 16'h0000);
      step();
      check("d1.rd1", {15'd0, IMem_Rd}, 16'h0000);
      step();
      IMem_Done = 1'b1; IMem_Data = 16'hDEAD; #1;
      check("d1.rd2", {15'd0, IMem_Rd}, 16'h0000);
      step();
      IMem_Done = 1'b0; #1;
      check("d1.rd",    {15'd0, IMem_Rd}, 16'h0001);
      check("d1.addr",  IMem_Addr, 16'h0080);
      check("d1.instr", Instr_ff, 16'h0800);
      check("d1.valid", {15'd0, Valid_ff}, 16'h0000);

      // stall across Done
      step();
      Stall = 1'b1; IMem_Done = 1'b1; IMem_Data = 16'hA5A5; #1;
      step();
      IMem_Done = 1'b0; #1;
      check("s1.rd",    {15'd0, IMem_Rd}, 16'h0000);
      chk_ifid("s1.held", 16'h0800, 16'h0002, 1'b0);
      step();
      chk_ifid("s1.held2", 16'h0800, 16'h0002, 1'b0);
      Stall = 1'b0; #1;
      step();
      chk_ifid("s1.rel", 16'hA5A5, 16'h0082, 1'b1);
      check("s1.rd2",   {15'd0, IMem_Rd}, 16'h0001);
      check("s1.addr2", IMem_Addr, 16'h0082);

      // halt with a request outstanding
      step();
      Halt_D = 1'b1; #1;
      step();
      Halt_D = 1'b0; #1;
      check("h1.rd0", {15'd0, IMem_Rd}, 16'h0000);
      IMem_Done = 1'b1; IMem_Data = 16'hBEEF; #1;
      step();
      IMem_Done = 1'b0; #1;
      check("h1.halted", {15'd0, Halted}, 16'h0001);
      check("h1.rd1",    {15'd0, IMem_Rd}, 16'h0000);
      check("h1.valid",  {15'd0, Valid_ff}, 16'h0000);
      step();
      check("h1.rd2",    {15'd0, IMem_Rd}, 16'h0000);
      check("h1.halted2",{15'd0, Halted}, 16'h0001);
      Redirect = 1'b1; PC_Redirect = 16'h0010; #1;
      check("h1.rd3",    {15'd0, IMem_Rd}, 16'h0000);
      step();
      Redirect = 1'b0; #1;
      check("h1.resume_halted", {15'd0, Halted}, 16'h0000);
      check("h1.resume_rd",     {15'd0, IMem_Rd}, 16'h0001);
      check("h1.resume_addr",   IMem_Addr, 16'h0010);

      // PC wrap at FFFE
      Redirect = 1'b1; PC_Redirect = 16'hFFFE; #1;
      check("w1.rd_sup", {15'd0, IMem_Rd}, 16'h0000);
      step();
      Redirect = 1'b0; #1;
      check("w1.rd",   {15'd0, IMem_Rd}, 16'h0001);
      check("w1.addr", IMem_Addr, 16'hFFFE);
      step();
      IMem_Done = 1'b1; IMem_Data = 16'h7777; #1;
      step();
      IMem_Done = 1'b0; #1;
      chk_ifid("w1", 16'h7777, 16'h0000, 1'b1);
      check("w1.next_addr", IMem_Addr, 16'h0000);

      // asynchronous reset while in WAIT
      step();
      #2 rst = 1'b1;
      #1;
      check("ar.rd",     {15'd0, IMem_Rd}, 16'h0000);
      check("ar.addr",   IMem_Addr, 16'h0000);
      check("ar.halted", {15'd0, Halted}, 16'h0000);
      chk_ifid("ar", 16'h0800, 16'h0000, 1'b0);
      step();
      rst = 1'b0; #1;
      check("ar.post_rd",   {15'd0, IMem_Rd}, 16'h0001);
      check("ar.post_addr", IMem_Addr, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
